// File: rtl/arb16_rr_if.sv
// arb16_rr_if: request/grant bundle between the clients and the round-robin arbiter.
// master = client/datapath side, slave = arbiter side.
interface arb16_rr_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        start;
  logic        timeout_err;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, start, timeout_err
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, start, timeout_err
  );
endinterface

// File: rtl/arb16_rr.sv
// arb16_rr: 16-way round-robin arbiter, registered one-hot grant held until release, then GAP idle cycles.
// Define ARB16_TIMEOUT_EN to force release (and pulse timeout_err) after TIMEOUT busy cycles.
module arb16_rr #(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic      clk,
  input  logic      rst,
  arb16_rr_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP_WAIT} state_t;

  state_t      state, state_n;
  logic [3:0]  last, last_n;
  logic [3:0]  gap_cnt, gap_cnt_n;
  logic [15:0] grant_r, grant_n;
  logic [3:0]  grant_id_r, grant_id_n;
  logic        grant_valid_r, grant_valid_n;
  logic        start_r, start_n;
  logic [15:0] masked, pick_src;
  logic [3:0]  sel_id;
  logic        sel_hit;
  logic        release_now;
  logic        tmo;

  if (GAP < 0 || GAP > 15 || TIMEOUT < 1) begin : g_param_check
    $error("arb16_rr: GAP must be 0..15 and TIMEOUT >= 1");
  end

`ifdef ARB16_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  logic [CW-1:0] busy_cnt, busy_cnt_n;
  logic          terr_r, terr_n;

  assign tmo             = (busy_cnt == CW'(TIMEOUT - 1));
  assign bus.timeout_err = terr_r;
`else
  assign tmo             = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant       = grant_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.start       = start_r;

  // Clients above the last winner get first pick; fall back to the whole vector on wrap.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < 16; i++)
      masked[i] = bus.req[i] && (i > 32'(last));
    pick_src = (masked != '0) ? masked : bus.req;
    sel_id   = '0;
    sel_hit  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!sel_hit && pick_src[i]) begin
        sel_hit = 1'b1;
        sel_id  = 4'(i);
      end
    end
  end

  assign release_now = bus.done || !bus.req[grant_id_r] || tmo;

  always_comb begin
    state_n       = state;
    last_n        = last;
    gap_cnt_n     = gap_cnt;
    grant_n       = grant_r;
    grant_id_n    = grant_id_r;
    grant_valid_n = grant_valid_r;
    start_n       = 1'b0;
`ifdef ARB16_TIMEOUT_EN
    busy_cnt_n    = busy_cnt;
    terr_n        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.req != '0) begin
          state_n       = BUSY;
          last_n        = sel_id;
          grant_n       = 16'd1 << sel_id;
          grant_id_n    = sel_id;
          grant_valid_n = 1'b1;
          start_n       = 1'b1;
`ifdef ARB16_TIMEOUT_EN
          busy_cnt_n    = '0;
`endif
        end
      end
      BUSY: begin
`ifdef ARB16_TIMEOUT_EN
        busy_cnt_n = busy_cnt + 1'b1;
`endif
        if (release_now) begin
          grant_n       = '0;
          grant_id_n    = '0;
          grant_valid_n = 1'b0;
`ifdef ARB16_TIMEOUT_EN
          // A real release (done or abandon) in the timeout cycle wins over the timeout flag.
          terr_n        = !bus.done && bus.req[grant_id_r];
`endif
          if (GAP == 0) begin
            state_n = IDLE;
          end else begin
            state_n   = GAP_WAIT;
            gap_cnt_n = '0;
          end
        end
      end
      GAP_WAIT: begin
        if (gap_cnt == 4'(GAP - 1)) state_n = IDLE;
        else                        gap_cnt_n = gap_cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 4'd15;
      gap_cnt       <= '0;
      grant_r       <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      start_r       <= 1'b0;
    end else begin
      state         <= state_n;
      last          <= last_n;
      gap_cnt       <= gap_cnt_n;
      grant_r       <= grant_n;
      grant_id_r    <= grant_id_n;
      grant_valid_r <= grant_valid_n;
      start_r       <= start_n;
    end
  end

`ifdef ARB16_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
      terr_r   <= 1'b0;
    end else begin
      busy_cnt <= busy_cnt_n;
      terr_r   <= terr_n;
    end
  end
`endif

endmodule

// File: tb/tb_arb16_rr.sv
// tb_arb16_rr: table-driven and sequence checks of arb16_rr (GAP=1, TIMEOUT=8) through a scoreboard queue.
module tb_arb16_rr;
  logic clk = 1'b0;
  logic rst;

  arb16_rr_if bus ();

  arb16_rr #(.GAP(1), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  id;
    logic        valid;
    logic        start;
    logic        terr;
    string       name;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic [15:0] q, input logic d,
                              input logic [15:0] g, input logic [3:0] id, input logic vl,
                              input logic st, input logic te, input string nm);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.grant = g; v.id = id;
    v.valid = vl; v.start = st; v.terr = te; v.name = nm;
    return v;
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input vec_t v);
    rst      = v.rst;
    bus.req  = v.req;
    bus.done = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [15:0] q, input logic d, input logic [3:0] id,
                      input logic st, input string nm);
    step(mk(1'b0, q, d, 16'd1 << id, id, 1'b1, st, 1'b0, nm));
  endtask

  task automatic idle(input logic r, input logic [15:0] q, input logic d,
                      input logic te, input string nm);
    step(mk(r, q, d, '0, '0, 1'b0, 1'b0, te, nm));
  endtask

  // Monitor: invariants every cycle, plus the queued expectation for this edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      n_checks++;
      if (!$onehot0(bus.grant)) begin
        n_fail++;
        $display("FAIL onehot: grant=%h required zero or one-hot", bus.grant);
      end
      n_checks++;
      if (bus.grant_valid !== (|bus.grant)) begin
        n_fail++;
        $display("FAIL valid_vs_grant: grant_valid=%b required %b", bus.grant_valid, |bus.grant);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.grant, bus.grant_id, bus.grant_valid, bus.start, bus.timeout_err} !==
            {e.grant, e.id, e.valid, e.start, e.terr}) begin
          n_fail++;
          $display("FAIL %s: got grant=%h id=%0d valid=%b start=%b terr=%b, required grant=%h id=%0d valid=%b start=%b terr=%b",
                   e.name, bus.grant, bus.grant_id, bus.grant_valid, bus.start, bus.timeout_err,
                   e.grant, e.id, e.valid, e.start, e.terr);
        end
      end
    end
  end

  initial begin
    vec_t tbl[18];
    tbl[0]  = mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "reset");
    tbl[1]  = mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "reset_hold");
    tbl[2]  = mk(0, 16'h0001, 0, 16'h0001, 0, 1, 1, 0, "t1_grant0");
    tbl[3]  = mk(0, 16'h0001, 0, 16'h0001, 0, 1, 0, 0, "t1_start_once");
    tbl[4]  = mk(0, 16'h0001, 1, 16'h0000, 0, 0, 0, 0, "t1_release");
    tbl[5]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "t1_gap");
    tbl[6]  = mk(0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, "t5_done_in_idle");
    tbl[7]  = mk(0, 16'h0002, 0, 16'h0002, 1, 1, 1, 0, "t5_grant1");
    tbl[8]  = mk(0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, "t5_done_and_drop");
    tbl[9]  = mk(0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, "t5_done_in_gap");
    tbl[10] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "t5_idle");
    tbl[11] = mk(0, 16'h0002, 0, 16'h0002, 1, 1, 1, 0, "regrant1_wrap");
    tbl[12] = mk(0, 16'h0006, 0, 16'h0002, 1, 1, 0, 0, "other_req_no_disturb");
    tbl[13] = mk(0, 16'h0006, 1, 16'h0000, 0, 0, 0, 0, "release1");
    tbl[14] = mk(0, 16'h0004, 0, 16'h0000, 0, 0, 0, 0, "no_grant_in_gap");
    tbl[15] = mk(0, 16'h0004, 0, 16'h0004, 2, 1, 1, 0, "grant2");
    tbl[16] = mk(0, 16'h0004, 1, 16'h0000, 0, 0, 0, 0, "release2");
    tbl[17] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "gap2");

    rst = 1'b1; bus.req = '0; bus.done = 1'b0;
    for (int i = 0; i < 18; i++) step(tbl[i]);

    // Full rotation with every client requesting, ending in a wrap to 0.
    idle(1, 16'h0000, 0, 0, "t2_reset");
    for (int k = 0; k < 17; k++) begin
      hold(16'hFFFF, 0, 4'(k % 16), 1, "t2_rotate");
      idle(0, 16'hFFFF, 1, 0, "t2_release");
      idle(0, (k == 16) ? 16'h0000 : 16'hFFFF, 0, 0, "t2_gap");
    end

    // Rotation past the last winner: 4 -> 5 -> 11 -> 0.
    hold(16'h0010, 0, 4, 1, "t3_grant4");
    idle(0, 16'h0010, 1, 0, "t3_rel4");
    idle(0, 16'h0000, 0, 0, "t3_gap4");
    hold(16'h0821, 0, 5, 1, "t3_grant5");
    idle(0, 16'h0821, 1, 0, "t3_rel5");
    idle(0, 16'h0821, 0, 0, "t3_gap5");
    hold(16'h0821, 0, 11, 1, "t3_grant11");
    idle(0, 16'h0821, 1, 0, "t3_rel11");
    idle(0, 16'h0821, 0, 0, "t3_gap11");
    hold(16'h0821, 0, 0, 1, "t3_grant0");
    idle(0, 16'h0821, 1, 0, "t3_rel0");
    idle(0, 16'h0000, 0, 0, "t3_gap0");

    // Grantee abandons its request without done.
    hold(16'h0018, 0, 3, 1, "t4_grant3");
    hold(16'h0018, 0, 3, 0, "t4_hold3");
    idle(0, 16'h0010, 0, 0, "t4_abandon");
    idle(0, 16'h0010, 0, 0, "t4_gap");
    hold(16'h0010, 0, 4, 1, "t4_next4");
    idle(0, 16'h0010, 1, 0, "t4_rel4");
    idle(0, 16'h0000, 0, 0, "t4_gap4");

    // Reset mid-grant resets the rotation pointer.
    hold(16'h0080, 0, 7, 1, "t6_grant7");
    hold(16'h0180, 0, 7, 0, "t6_hold7");
    idle(1, 16'h0180, 0, 0, "t6_rst_busy");
    hold(16'h0180, 0, 7, 1, "t6_after_rst7");
    idle(0, 16'h0180, 1, 0, "t6_rel7");
    idle(0, 16'h0000, 0, 0, "t6_gap");

`ifdef ARB16_TIMEOUT_EN
    hold(16'h0004, 0, 2, 1, "t7_grant2");
    for (int c = 0; c < 7; c++) hold(16'h0004, 0, 2, 0, "t7_busy");
    idle(0, 16'h0004, 0, 1, "t7_timeout");
    idle(0, 16'h0004, 0, 0, "t7_terr_once");
    hold(16'h0004, 0, 2, 1, "t7_regrant2");
    for (int c = 0; c < 7; c++) hold(16'h0004, 0, 2, 0, "t7_busy2");
    idle(0, 16'h0004, 1, 0, "t7_done_at_timeout");
    idle(0, 16'h0000, 0, 0, "t7_gap");
`else
    hold(16'h0004, 0, 2, 1, "t7_grant2");
    for (int c = 0; c < 20; c++) hold(16'h0004, 0, 2, 0, "t7_held_no_timeout");
    idle(0, 16'h0004, 1, 0, "t7_release");
    idle(0, 16'h0000, 0, 0, "t7_gap");
`endif

    rst = 1'b0; bus.req = '0; bus.done = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
